mealy_stream_ctrl: RTL and testbench

- Serialises W-bit input words, LSB first, into the 4-state Mealy machine (states Sa..Sd, 1-bit input, 3-bit output).
- Owns the Mealy state register and next-state logic; instantiates the combinational output decoder.
- Emits one 3-bit symbol per bit over a valid/ready output handshake, then pulses `done` with a per-word Sd-hit count.
- Sits between a word producer and a symbol consumer in the lab datapath.

---
 rtl/mealy_pkg.sv | 33 +++
 rtl/mealy_out_dec.sv | 23 ++
 rtl/mealy_stream_ctrl.sv | 118 +++++++++++
 tb/tb_mealy_stream_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mealy_pkg.sv
// Shared types and next-state table for the 4-state Mealy serialiser.
// Combinational helpers only; no latency.
// Backpressure: not applicable.
package mealy_pkg;

    typedef enum logic [1:0] {
        SA = 2'd0,
        SB = 2'd1,
        SC = 2'd2,
        SD = 2'd3
    } mstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_t;

    localparam logic [2:0] SYM_IDLE = 3'b000;

    function automatic mstate_t mealy_next(input mstate_t s, input logic b);
        mstate_t n;
        case (s)
            SA:      n = b ? SC : SB;
            SB:      n = b ? SD : SC;
            SC:      n = b ? SD : SA;
            SD:      n = SA;
            default: n = SA;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mealy_out_dec.sv
// Mealy output decoder: (state, bit) -> 3-bit symbol.
// Purely combinational, zero latency.
// Backpressure: none; output follows inputs.
module mealy_out_dec
    import mealy_pkg::*;
(
    input  mstate_t    state,
    input  logic       data_bit,
    output logic [2:0] sym
);

    always_comb begin
        sym = SYM_IDLE;
        case (state)
            SA:      sym = data_bit ? 3'b101 : 3'b111;
            SB:      sym = data_bit ? 3'b011 : 3'b001;
            SC:      sym = data_bit ? 3'b100 : 3'b000;
            SD:      sym = 3'b110;
            default: sym = SYM_IDLE;
        endcase
    end

endmodule

// File: rtl/mealy_stream_ctrl.sv
// Serialises W-bit words LSB first through a Mealy machine, one symbol per handshake.
// Latency: first symbol one cycle after accept; done one cycle after the last symbol.
// Backpressure: out_ready low freezes symbol, Mealy state and bit index.
module mealy_stream_ctrl
    import mealy_pkg::*;
#(
    parameter  int W  = 8,
    localparam int IW = (W > 1) ? $clog2(W) : 1,
    localparam int SW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_word,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    out_sym,
    output logic          done,
    output logic [SW-1:0] sd_hits,
    output logic [1:0]    mstate
);

    ctrl_t         ctrl_q,   ctrl_d;
    mstate_t       mstate_q, mstate_d;
    logic [IW-1:0] idx_q,    idx_d;
    logic [W-1:0]  word_q,   word_d;
    logic [SW-1:0] sd_q,     sd_d;

    logic       accept;
    logic       hs;
    logic       last_bit;
    logic       cur_bit;
    logic [2:0] dec_sym;

    assign in_ready  = (ctrl_q == IDLE) && !clear;
    assign accept    = in_valid && in_ready;
    assign out_valid = (ctrl_q == RUN);
    assign hs        = out_valid && out_ready;
    assign last_bit  = (idx_q == IW'(W - 1));
    assign cur_bit   = word_q[idx_q];

    mealy_out_dec u_dec (
        .state    (mstate_q),
        .data_bit (cur_bit),
        .sym      (dec_sym)
    );

    assign out_sym = out_valid ? dec_sym : SYM_IDLE;
    assign done    = (ctrl_q == DONE);
    assign sd_hits = sd_q;
    assign mstate  = mstate_q;

    always_comb begin
        ctrl_d   = ctrl_q;
        mstate_d = mstate_q;
        idx_d    = idx_q;
        word_d   = word_q;
        sd_d     = sd_q;

        // clear outranks any handshake; sd_hits is deliberately left intact
        if (clear) begin
            ctrl_d   = IDLE;
            mstate_d = SA;
            idx_d    = '0;
        end else begin
            case (ctrl_q)
                IDLE: begin
                    if (accept) begin
                        word_d = in_word;
                        idx_d  = '0;
                        sd_d   = '0;
                        ctrl_d = RUN;
                    end
                end
                RUN: begin
                    if (hs) begin
                        mstate_d = mealy_next(mstate_q, cur_bit);
                        if ((mstate_q == SD) && (sd_q != SW'(W)))
                            sd_d = sd_q + SW'(1);
                        if (last_bit) begin
                            idx_d  = '0;
                            ctrl_d = DONE;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end
                end
                DONE: begin
                    idx_d  = '0;
                    ctrl_d = IDLE;
                end
                default: begin
                    idx_d  = '0;
                    ctrl_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= IDLE;
            mstate_q <= SA;
            idx_q    <= '0;
            word_q   <= '0;
            sd_q     <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            mstate_q <= mstate_d;
            idx_q    <= idx_d;
            word_q   <= word_d;
            sd_q     <= sd_d;
        end
    end

endmodule

// File: tb/tb_mealy_stream_ctrl.sv
// Directed bench for mealy_stream_ctrl: table of words plus clear and async-reset sequences.
module tb_mealy_stream_ctrl;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_word;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_sym;
    logic       done;
    logic [3:0] sd_hits;
    logic [1:0] mstate;

    int checks = 0;
    int errors = 0;
    logic [1:0] m_model;

    always #5 clk = ~clk;

    mealy_stream_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sym   (out_sym),
        .done      (done),
        .sd_hits   (sd_hits),
        .mstate    (mstate)
    );

    typedef struct {
        logic        pre_clear;
        logic [7:0]  word;
        logic [23:0] syms;     // symbol i at [3*i +: 3]
        logic [1:0]  end_st;
        logic [3:0]  hits;
        int          bp;       // bit index where out_ready drops for 3 cycles
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] tb_next(input logic [1:0] s, input logic b);
        case (s)
            2'd0:    return b ? 2'd2 : 2'd1;
            2'd1:    return b ? 2'd3 : 2'd2;
            2'd2:    return b ? 2'd3 : 2'd0;
            default: return 2'd0;
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  in_ready,  1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_done"},      done,      0);
        chk({tag, "_sd_hits"},   sd_hits,   0);
        chk({tag, "_mstate"},    mstate,    0);
        chk({tag, "_out_sym"},   out_sym,   0);
    endtask

    task automatic run_word(input vec_t v);
        logic [2:0] exp;
        @(negedge clk);
        if (v.pre_clear) begin
            clear    = 1'b1;
            in_valid = 1'b1;
            in_word  = v.word;
            #1;
            chk("in_ready_under_clear", in_ready, 0);
            m_model = 2'd0;
            @(negedge clk);
        end
        clear     = 1'b0;
        in_valid  = 1'b1;
        in_word   = v.word;
        out_ready = 1'b1;
        #1;
        chk("accept_in_ready", in_ready, 1);
        chk("accept_out_valid", out_valid, 0);
        for (int i = 0; i < W; i++) begin
            exp = v.syms[3*i +: 3];
            if (i == v.bp) begin
                repeat (3) begin
                    @(negedge clk);
                    out_ready = 1'b0;
                    in_word   = ~v.word;
                    #1;
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_out_sym", out_sym, exp);
                    chk("stall_mstate", mstate, m_model);
                end
            end
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_word   = ~v.word;
            #1;
            chk("run_out_valid", out_valid, 1);
            chk("run_out_sym", out_sym, exp);
            chk("run_mstate", mstate, m_model);
            chk("run_in_ready", in_ready, 0);
            chk("run_done", done, 0);
            m_model = tb_next(m_model, v.word[i]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("done_pulse", done, 1);
        chk("done_sd_hits", sd_hits, v.hits);
        chk("done_mstate", mstate, v.end_st);
        chk("done_out_valid", out_valid, 0);
        chk("done_in_ready", in_ready, 0);
        chk("done_out_sym", out_sym, 0);
    endtask

    initial begin
        logic [2:0] csym[4];
        logic       seen_done;

        tbl[0] = '{1'b0, 8'h00,
                   {3'b001, 3'b111, 3'b000, 3'b001, 3'b111, 3'b000, 3'b001, 3'b111},
                   2'd2, 4'd0, 99};
        tbl[1] = '{1'b1, 8'hFF,
                   {3'b100, 3'b101, 3'b110, 3'b100, 3'b101, 3'b110, 3'b100, 3'b101},
                   2'd3, 4'd2, 99};
        tbl[2] = '{1'b0, 8'h00,
                   {3'b111, 3'b000, 3'b001, 3'b111, 3'b000, 3'b001, 3'b111, 3'b110},
                   2'd1, 4'd1, 99};
        tbl[3] = '{1'b0, 8'hA5,
                   {3'b101, 3'b110, 3'b011, 3'b111, 3'b000, 3'b101, 3'b110, 3'b011},
                   2'd2, 4'd2, 4};
        csym = '{3'b100, 3'b110, 3'b101, 3'b100};

        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_word   = 8'h00;
        m_model   = 2'd0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 4; n++) run_word(tbl[n]);

        @(negedge clk);
        #1;
        chk("idle_after_words_in_ready", in_ready, 1);
        chk("idle_after_words_done", done, 0);

        // abort a word at bit 3 with clear while the consumer is ready
        in_valid  = 1'b1;
        in_word   = 8'hFF;
        out_ready = 1'b1;
        #1;
        chk("clr_accept_in_ready", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk("clr_run_out_sym", out_sym, csym[i]);
            chk("clr_run_mstate", mstate, m_model);
            m_model = tb_next(m_model, 1'b1);
        end
        @(negedge clk);
        clear = 1'b1;
        #1;
        chk("clr_bit3_out_sym", out_sym, csym[3]);
        chk("clr_bit3_out_valid", out_valid, 1);
        chk("clr_bit3_in_ready", in_ready, 0);
        @(negedge clk);
        clear   = 1'b0;
        m_model = 2'd0;
        #1;
        chk("clr_after_in_ready", in_ready, 1);
        chk("clr_after_mstate", mstate, 0);
        chk("clr_after_out_valid", out_valid, 0);
        chk("clr_after_sd_hits", sd_hits, 1);
        seen_done = done;
        repeat (W + 2) begin
            @(negedge clk);
            #1;
            seen_done = seen_done | done;
        end
        chk("clr_no_done", seen_done, 0);

        // asynchronous reset in the middle of a word
        @(negedge clk);
        in_valid = 1'b1;
        in_word  = 8'h0F;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        #1;
        chk("arst_pre_mstate", mstate, 2);
        chk("arst_pre_out_valid", out_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_outputs("arst_release");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
